// File: rtl/sw_linear_array_pkg.sv
// Shared types and score helpers for the linear Smith-Waterman array.
package sw_linear_array_pkg;

  typedef logic [1:0] score_t;
  typedef logic [1:0] base_t;

  localparam base_t  BASE_A    = 2'b00;
  localparam base_t  BASE_C    = 2'b01;
  localparam base_t  BASE_G    = 2'b10;
  localparam base_t  BASE_T    = 2'b11;
  localparam score_t SCORE_MAX = 2'd3;

  typedef struct packed {
    logic  valid;
    logic  first;
    base_t base;
  } token_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Gap penalty: one point per gap, floored at zero.
  function automatic score_t gap_add(input score_t x);
    return (x == 2'd0) ? 2'd0 : x - 2'd1;
  endfunction

endpackage

// File: rtl/sw_linear_array_pe.sv
// One processing element: holds a query base and scores one matrix row
// as database tokens stream past.
module sw_linear_array_pe
  import sw_linear_array_pkg::*;
#(
  parameter int POS_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             qShift_i,
  input  logic [1:0]       qBase_i,
  output logic [1:0]       qBase_o,
  input  logic             advance_i,
  input  token_t           tok_i,
  input  logic [POS_W-1:0] pos_i,
  input  logic [1:0]       up_i,
  output token_t           tok_o,
  output logic [POS_W-1:0] pos_o,
  output logic [1:0]       h_o
);

  base_t            query_q;
  token_t           tok_q;
  logic [POS_W-1:0] pos_q;
  score_t           h_q, left_q, diag_q;
  score_t           leftS, diagS, diagTerm, upGap, leftGap, hD;

  // The first column of a sequence sees zero left/diag neighbours.
  always_comb begin
    leftS = tok_i.first ? 2'd0 : left_q;
    diagS = tok_i.first ? 2'd0 : diag_q;
    if (tok_i.base == query_q) begin
      diagTerm = (diagS == SCORE_MAX) ? SCORE_MAX : diagS + 2'd1;
    end else begin
      diagTerm = (diagS == 2'd0) ? 2'd0 : diagS - 2'd1;
    end
    upGap   = gap_add(up_i);
    leftGap = gap_add(leftS);
    hD      = diagTerm;
    if (upGap > hD)   hD = upGap;
    if (leftGap > hD) hD = leftGap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      query_q <= '0;
      tok_q   <= '0;
      pos_q   <= '0;
      h_q     <= '0;
      left_q  <= '0;
      diag_q  <= '0;
    end else begin
      if (qShift_i) query_q <= qBase_i;
      if (advance_i) begin
        tok_q <= tok_i;
        pos_q <= pos_i;
        h_q   <= tok_i.valid ? hD : 2'd0;
        if (tok_i.valid) begin
          left_q <= hD;
          diag_q <= up_i;
        end
      end
    end
  end

  assign qBase_o = query_q;
  assign tok_o   = tok_q;
  assign pos_o   = pos_q;
  assign h_o     = h_q;

endmodule

// File: rtl/sw_linear_array.sv
// Linear systolic Smith-Waterman array with query load, streaming, drain and
// result handshake. Optional row trace outputs under SW_ARRAY_ROW_TRACE_EN.
module sw_linear_array
  import sw_linear_array_pkg::*;
#(
  parameter int N      = 16,
  parameter int POS_W  = 16,
  parameter int THRESH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_valid_i,
  input  logic [1:0]       q_base_i,
  output logic             q_ready_o,
  input  logic             db_valid_i,
  input  logic [1:0]       db_base_i,
  input  logic             db_last_i,
  output logic             db_ready_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [1:0]       max_score_o,
  output logic [POS_W-1:0] max_pos_o,
  output logic             hit_o
`ifdef SW_ARRAY_ROW_TRACE_EN
  ,
  output logic             trace_valid_o,
  output logic [1:0]       trace_score_o
`endif
);

  localparam int QW = $clog2(N + 1);

  state_t           state_q, state_d;
  logic [QW-1:0]    qcnt_q, qcnt_d, drain_q, drain_d;
  logic             qLoaded_q, qLoaded_d;
  logic [POS_W-1:0] pos_q, pos_d;
  score_t           max_q, max_d;
  logic [POS_W-1:0] maxPos_q, maxPos_d;
  logic             hit_q;
  logic             qShift, dbReady, accept, advance;

  token_t           tokIn;
  logic [POS_W-1:0] posIn;
  token_t           tokPe [N];
  logic [POS_W-1:0] posPe [N];
  logic [1:0]       hPe   [N];
  logic [1:0]       qPe   [N];
  score_t           bestS;
  logic [POS_W-1:0] bestPos;

  // Query shifting during IDLE blocks database acceptance for that cycle.
  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    qLoaded_d = qLoaded_q;
    drain_d   = drain_q;
    pos_d     = pos_q;
    qShift    = 1'b0;
    dbReady   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (q_valid_i) begin
          qShift = 1'b1;
          if (qLoaded_q) begin
            qLoaded_d = 1'b0;
            qcnt_d    = QW'(1);
          end else begin
            qcnt_d = qcnt_q + 1'b1;
            if (qcnt_q == QW'(N - 1)) qLoaded_d = 1'b1;
          end
        end else if (qLoaded_q) begin
          dbReady = 1'b1;
          if (db_valid_i) begin
            pos_d   = POS_W'(1);
            drain_d = '0;
            state_d = db_last_i ? ST_DRAIN : ST_RUN;
          end
        end
      end
      ST_RUN: begin
        dbReady = 1'b1;
        if (db_valid_i) begin
          pos_d = pos_q + 1'b1;
          if (db_last_i) begin
            drain_d = '0;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == QW'(N - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept      = dbReady & db_valid_i;
  assign advance     = accept | (state_q == ST_DRAIN);
  assign tokIn.valid = accept;
  assign tokIn.first = (state_q == ST_IDLE);
  assign tokIn.base  = db_base_i;
  assign posIn       = (state_q == ST_IDLE) ? '0 : pos_q;

  for (genvar g = 0; g < N; g++) begin : gPe
    if (g == 0) begin : gHead
      sw_linear_array_pe #(.POS_W(POS_W)) uPe (
        .clk(clk), .rst(rst),
        .qShift_i(qShift), .qBase_i(q_base_i), .qBase_o(qPe[g]),
        .advance_i(advance),
        .tok_i(tokIn), .pos_i(posIn), .up_i(2'd0),
        .tok_o(tokPe[g]), .pos_o(posPe[g]), .h_o(hPe[g])
      );
    end else begin : gBody
      sw_linear_array_pe #(.POS_W(POS_W)) uPe (
        .clk(clk), .rst(rst),
        .qShift_i(qShift), .qBase_i(qPe[g-1]), .qBase_o(qPe[g]),
        .advance_i(advance),
        .tok_i(tokPe[g-1]), .pos_i(posPe[g-1]), .up_i(hPe[g-1]),
        .tok_o(tokPe[g]), .pos_o(posPe[g]), .h_o(hPe[g])
      );
    end
  end

  // Ascending scan with >= lets the highest PE (earliest column) win ties.
  always_comb begin
    bestS   = '0;
    bestPos = '0;
    for (int i = 0; i < N; i++) begin
      if (tokPe[i].valid && (hPe[i] >= bestS)) begin
        bestS   = hPe[i];
        bestPos = posPe[i];
      end
    end
    max_d    = max_q;
    maxPos_d = maxPos_q;
    if (bestS > max_q) begin
      max_d    = bestS;
      maxPos_d = bestPos;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      qcnt_q    <= '0;
      qLoaded_q <= 1'b0;
      drain_q   <= '0;
      pos_q     <= '0;
      max_q     <= '0;
      maxPos_q  <= '0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      qLoaded_q <= qLoaded_d;
      drain_q   <= drain_d;
      pos_q     <= pos_d;
      if (accept && (state_q == ST_IDLE)) begin
        max_q    <= '0;
        maxPos_q <= '0;
        hit_q    <= 1'b0;
      end else if (advance) begin
        max_q    <= max_d;
        maxPos_q <= maxPos_d;
        hit_q    <= (max_d >= score_t'(THRESH));
      end
    end
  end

  assign q_ready_o   = (state_q == ST_IDLE);
  assign db_ready_o  = dbReady;
  assign res_valid_o = (state_q == ST_DONE);
  assign max_score_o = max_q;
  assign max_pos_o   = maxPos_q;
  assign hit_o       = hit_q;

`ifdef SW_ARRAY_ROW_TRACE_EN
  logic   traceValid_q;
  score_t traceScore_q;

  // Last-row score of every valid token leaving the array, one cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      traceValid_q <= 1'b0;
      traceScore_q <= '0;
    end else begin
      traceValid_q <= advance & tokPe[N-1].valid;
      traceScore_q <= hPe[N-1];
    end
  end

  assign trace_valid_o = traceValid_q;
  assign trace_score_o = traceScore_q;
`endif

endmodule
